// File: rtl/bram_rd_checker.sv
// -----------------------------------------------------------------------------
// bram_rd_checker
//
// Walks a BRAM read port from address 0 upward, trailing a writer that runs in
// the same clock domain, and checks every returned word against the pattern
// (address + DATA_OFFSET) mod 2^DATA_W. A run is opened by a start pulse. It
// closes after rd_count reads, or after a stop pulse when rd_count is 0. Reads
// that are still in flight are compared before the block returns to idle.
//
// Optional feature macro: BRAM_RD_CHK_CAPTURE_EN
//   When defined, the first failing address and data word of each run are
//   captured on first_err_addr / first_err_data.
//
// Ports
//   clk_in1        in   1       sole clock, rising edge
//   reset          in   1       asynchronous active-low reset
//   start          in   1       pulse: begin a run at address 0 (ignored while busy)
//   stop           in   1       pulse: end the run once in-flight reads retire
//   rd_count       in   16      words per run, 0 = run until stop
//   wr_addr        in   ADDR_W  writer's next write address (rd_addr == wr_addr is empty)
//   rd_en          out  1       BRAM read enable
//   rd_addr        out  ADDR_W  BRAM read address
//   rd_data        in   DATA_W  BRAM read data, valid RD_LATENCY clocks after rd_en
//   busy           out  1       high while a run or its drain is active
//   done           out  1       one-cycle pulse when the drain completes
//   mismatch       out  1       one-cycle pulse for each failing compare
//   err_cnt        out  16      saturating count of failing compares
//   chk_cnt        out  16      saturating count of compares
//   first_err_addr out  ADDR_W  (BRAM_RD_CHK_CAPTURE_EN only) first failing address
//   first_err_data out  DATA_W  (BRAM_RD_CHK_CAPTURE_EN only) first failing data word
// -----------------------------------------------------------------------------
module bram_rd_checker #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 10,
    parameter int RD_LATENCY  = 1,
    parameter int DATA_OFFSET = 0
) (
    input  logic              clk_in1,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [15:0]       rd_count,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [15:0]       err_cnt,
    output logic [15:0]       chk_cnt
`ifdef BRAM_RD_CHK_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic [DATA_W-1:0] first_err_data
`endif
);

    // Only latencies 1 and 2 are meaningful; anything else is clamped.
    localparam int LAT = (RD_LATENCY >= 2) ? 2 : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [15:0]         issued_q;
    logic [15:0]         limit_q;
    logic [15:0]         err_cnt_q;
    logic [15:0]         chk_cnt_q;
    logic                done_q;
    logic [LAT-1:0]      vld_q;
    logic [ADDR_W-1:0]   pa_q [LAT];

    logic                limit_hit_s;
    logic                issue_s;
    logic [15:0]         issued_d;
    logic                last_issue_s;
    logic                inflight_s;
    logic                cmp_s;
    logic [DATA_W-1:0]   exp_data_s;
    logic                mismatch_s;
    logic                start_run_s;

    // Counter increment that sticks at all-ones.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Expected BRAM contents for a given address.
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] a_ext;
        a_ext = DATA_W'(a);
        return a_ext + DATA_W'(DATA_OFFSET);
    endfunction

    // Issue decision and compare datapath for the current cycle.
    always_comb begin
        start_run_s  = (state_q == ST_IDLE) && start;
        // rd_count == 0 means no issue limit.
        limit_hit_s  = (limit_q != 16'd0) && (issued_q == limit_q);
        issue_s      = (state_q == ST_RUN) && (rd_addr_q != wr_addr) && !limit_hit_s;
        issued_d     = issue_s ? (issued_q + 16'd1) : issued_q;
        // The read that reaches the limit moves the FSM to DRAIN in the same edge.
        last_issue_s = (limit_q != 16'd0) && (issued_d == limit_q);
        inflight_s   = |vld_q;
        cmp_s        = vld_q[LAT-1];
        exp_data_s   = exp_data(pa_q[LAT-1]);
        mismatch_s   = cmp_s && (rd_data != exp_data_s);
    end

    // Run-control FSM: state, read address, issue count and done pulse.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rd_addr_q <= {ADDR_W{1'b0}};
            issued_q  <= 16'd0;
            limit_q   <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // start takes priority; stop is meaningless here.
                    if (start) begin
                        state_q   <= ST_RUN;
                        rd_addr_q <= {ADDR_W{1'b0}};
                        issued_q  <= 16'd0;
                        limit_q   <= rd_count;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        rd_addr_q <= rd_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        rd_addr_q <= rd_addr_q;
                    end
                    issued_q <= issued_d;
                    if (stop || last_issue_s) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_s) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-tracking pipeline: one valid bit and address per outstanding read.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            vld_q <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                pa_q[i] <= {ADDR_W{1'b0}};
            end
        end else begin
            vld_q[0] <= issue_s;
            pa_q[0]  <= rd_addr_q;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                pa_q[i]  <= pa_q[i-1];
            end
        end
    end

    // Compare and error counters, cleared when a run starts.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            err_cnt_q <= 16'd0;
            chk_cnt_q <= 16'd0;
        end else if (start_run_s) begin
            err_cnt_q <= 16'd0;
            chk_cnt_q <= 16'd0;
        end else begin
            if (cmp_s) begin
                chk_cnt_q <= sat_inc(chk_cnt_q);
            end
            if (mismatch_s) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

`ifdef BRAM_RD_CHK_CAPTURE_EN
    logic [ADDR_W-1:0] first_err_addr_q;
    logic [DATA_W-1:0] first_err_data_q;

    // Capture the first failing word of the run; err_cnt is still zero then.
    always_ff @(posedge clk_in1 or negedge reset) begin
        if (!reset) begin
            first_err_addr_q <= {ADDR_W{1'b0}};
            first_err_data_q <= {DATA_W{1'b0}};
        end else if (start_run_s) begin
            first_err_addr_q <= {ADDR_W{1'b0}};
            first_err_data_q <= {DATA_W{1'b0}};
        end else if (mismatch_s && (err_cnt_q == 16'd0)) begin
            first_err_addr_q <= pa_q[LAT-1];
            first_err_data_q <= rd_data;
        end
    end

    assign first_err_addr = first_err_addr_q;
    assign first_err_data = first_err_data_q;
`endif

    assign rd_en    = issue_s;
    assign rd_addr  = rd_addr_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign mismatch = mismatch_s;
    assign err_cnt  = err_cnt_q;
    assign chk_cnt  = chk_cnt_q;

endmodule

// File: tb/tb_bram_rd_checker.sv
`timescale 1ns/1ps
module tb_bram_rd_checker;

    localparam int AW  = 10;
    localparam int DW  = 10;
    localparam int OFF = 0;

    logic          clk_in1 = 1'b0;
    logic          reset, start, stop;
    logic [15:0]   rd_count;
    logic [AW-1:0] wr_addr;

    logic          rd_en0, rd_en1, busy0, busy1, done0, done1, mis0, mis1;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [DW-1:0] rd_data0, rd_data1, bq0, bq1a, bq1b;
    logic [15:0]   err0, err1, chk0, chk1;
`ifdef BRAM_RD_CHK_CAPTURE_EN
    logic [AW-1:0] fa0, fa1;
    logic [DW-1:0] fd0, fd1;
`endif

    logic [DW-1:0] mem [1024];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk_in1 = ~clk_in1;

    bram_rd_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .DATA_OFFSET(OFF)) u_dut0 (
        .clk_in1(clk_in1), .reset(reset), .start(start), .stop(stop),
        .rd_count(rd_count), .wr_addr(wr_addr), .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .busy(busy0), .done(done0), .mismatch(mis0),
        .err_cnt(err0), .chk_cnt(chk0)
`ifdef BRAM_RD_CHK_CAPTURE_EN
        , .first_err_addr(fa0), .first_err_data(fd0)
`endif
    );

    bram_rd_checker #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(2), .DATA_OFFSET(OFF)) u_dut1 (
        .clk_in1(clk_in1), .reset(reset), .start(start), .stop(stop),
        .rd_count(rd_count), .wr_addr(wr_addr), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .busy(busy1), .done(done1), .mismatch(mis1),
        .err_cnt(err1), .chk_cnt(chk1)
`ifdef BRAM_RD_CHK_CAPTURE_EN
        , .first_err_addr(fa1), .first_err_data(fd1)
`endif
    );

    // BRAM read ports with latency 1 and 2
    always @(posedge clk_in1) begin
        bq0  <= mem[rd_addr0];
        bq1a <= mem[rd_addr1];
        bq1b <= bq1a;
    end
    assign rd_data0 = bq0;
    assign rd_data1 = bq1b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_of(input int a);
        int v;
        v = (a + OFF) % 1024;
        return DW'(v);
    endfunction

    // ---------------- reference model (one per DUT, k = latency-1) -----------
    int m_addr[2], m_iss[2], m_lim[2], m_err[2], m_chk[2];
    bit m_run[2], m_drn[2], m_dn[2];
    bit h_en[2][3];
    bit h_bad[2][3];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = 0; m_iss[k] = 0; m_lim[k] = 0; m_err[k] = 0; m_chk[k] = 0;
            m_run[k] = 1'b0; m_drn[k] = 1'b0; m_dn[k] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                h_en[k][j] = 1'b0; h_bad[k][j] = 1'b0;
            end
        end
    endtask

    task automatic eval_dut(input int k, input logic en, input logic [AW-1:0] addr,
                            input logic bsy, input logic dn, input logic mis,
                            input logic [15:0] ec, input logic [15:0] cc);
        int L;
        bit avail, inflight, bad;
        L = k + 1;
        avail = m_run[k] && (m_addr[k] != int'(wr_addr)) &&
                !((m_lim[k] != 0) && (m_iss[k] == m_lim[k]));
        check_val($sformatf("d%0d_rd_en", k),    en,  avail);
        check_val($sformatf("d%0d_rd_addr", k),  addr, m_addr[k]);
        check_val($sformatf("d%0d_busy", k),     bsy, m_run[k] || m_drn[k]);
        check_val($sformatf("d%0d_done", k),     dn,  m_dn[k]);
        check_val($sformatf("d%0d_mismatch", k), mis, h_en[k][L] && h_bad[k][L]);
        check_val($sformatf("d%0d_err_cnt", k),  ec,  m_err[k]);
        check_val($sformatf("d%0d_chk_cnt", k),  cc,  m_chk[k]);
        if (reset) begin
            inflight = h_en[k][1] || ((L == 2) && h_en[k][2]);
            if (h_en[k][L]) begin
                if (m_chk[k] < 65535) m_chk[k]++;
                if (h_bad[k][L] && m_err[k] < 65535) m_err[k]++;
            end
            bad = avail && (mem[m_addr[k]] !== exp_of(m_addr[k]));
            h_en[k][2] = h_en[k][1];   h_en[k][1] = avail;
            h_bad[k][2] = h_bad[k][1]; h_bad[k][1] = bad;
            if (!m_run[k] && !m_drn[k]) begin
                m_dn[k] = 1'b0;
                if (start) begin
                    m_run[k] = 1'b1; m_addr[k] = 0; m_iss[k] = 0;
                    m_lim[k] = int'(rd_count); m_err[k] = 0; m_chk[k] = 0;
                end
            end else if (m_run[k]) begin
                m_dn[k] = 1'b0;
                if (avail) begin
                    m_addr[k] = (m_addr[k] + 1) % 1024;
                    m_iss[k]++;
                end
                if (stop || ((m_lim[k] != 0) && (m_iss[k] == m_lim[k]))) begin
                    m_run[k] = 1'b0; m_drn[k] = 1'b1;
                end
            end else begin
                m_dn[k] = !inflight;
                if (!inflight) m_drn[k] = 1'b0;
            end
        end
    endtask

    // Per-cycle comparison of both DUTs against the model, away from the edge.
    always @(negedge clk_in1) begin
        if (!reset) model_reset();
        eval_dut(0, rd_en0, rd_addr0, busy0, done0, mis0, err0, chk0);
        eval_dut(1, rd_en1, rd_addr1, busy1, done1, mis1, err1, chk1);
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic step();
        @(posedge clk_in1);
        #1;
    endtask

    task automatic write_one(input bit corrupt);
        logic [DW-1:0] flip;
        flip = corrupt ? DW'($urandom_range(1, 1023)) : '0;
        mem[wr_addr] = exp_of(int'(wr_addr)) ^ flip;
        wr_addr = wr_addr + 10'd1;
    endtask

    function automatic bit may_write();
        int nxt;
        nxt = (int'(wr_addr) + 1) % 1024;
        return (nxt != m_addr[0]) && (nxt != m_addr[1]);
    endfunction

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int d0, output int d1);
        int n;
        n = 0; d0 = 0; d1 = 0;
        do begin
            step(); n++;
            d0 += int'(done0); d1 += int'(done1);
        end while ((busy0 || busy1) && n < budget);
        check_val("idle_timeout", busy0 | busy1, 1'b0);
    endtask

    // ---------------- test sequence -----------------------------------------
    initial begin
        int d0, d1, w, n;
        reset = 1'b0; start = 1'b0; stop = 1'b0; rd_count = 16'd0; wr_addr = '0;
        for (int i = 0; i < 1024; i++) mem[i] = exp_of(i);
        repeat (3) @(posedge clk_in1);
        #1 reset = 1'b1;

        // 16 correct words, rd_count 16
        for (int i = 0; i < 16; i++) begin write_one(1'b0); step(); end
        rd_count = 16'd16;
        pulse_start();
        wait_idle(100, d0, d1);
        check_val("t1_chk0", chk0, 16); check_val("t1_chk1", chk1, 16);
        check_val("t1_err0", err0, 0);  check_val("t1_err1", err1, 0);
        check_val("t1_done0", d0, 1);   check_val("t1_done1", d1, 1);
        check_val("t1_busy0", busy0, 0);

        // addr 5 holds 7, rd_count 8
        mem[5] = 10'd7;
        rd_count = 16'd8;
        pulse_start();
        wait_idle(100, d0, d1);
        check_val("t2_err0", err0, 1); check_val("t2_err1", err1, 1);
        check_val("t2_chk0", chk0, 8); check_val("t2_chk1", chk1, 8);
`ifdef BRAM_RD_CHK_CAPTURE_EN
        check_val("t2_fa0", fa0, 5); check_val("t2_fd0", fd0, 7);
        check_val("t2_fa1", fa1, 5); check_val("t2_fd1", fd1, 7);
`endif
        mem[5] = exp_of(5);

        // writer stalled at 3, then 6, continuous run ended by stop
        wr_addr = 10'd3; rd_count = 16'd0;
        pulse_start();
        repeat (10) step();
        check_val("t3_stall_addr0", rd_addr0, 3); check_val("t3_stall_en0", rd_en0, 0);
        check_val("t3_stall_addr1", rd_addr1, 3);
        wr_addr = 10'd6;
        repeat (10) step();
        check_val("t3_addr6", rd_addr0, 6);
        pulse_stop();
        wait_idle(100, d0, d1);
        check_val("t3_chk0", chk0, 6); check_val("t3_chk1", chk1, 6);
        check_val("t3_done0", d0, 1);  check_val("t3_done1", d1, 1);

        // start and stop together in IDLE; then start while busy
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        step();
        check_val("t4_busy0", busy0, 1); check_val("t4_busy1", busy1, 1);
        repeat (10) step();
        pulse_start();
        step();
        check_val("t4_keep_chk0", chk0, 6); check_val("t4_keep_chk1", chk1, 6);
        pulse_stop();
        wait_idle(100, d0, d1);

        // continuous run with the writer wrapping 1023 -> 0
        rd_count = 16'd0;
        pulse_start();
        w = 0; n = 0;
        while (w < 1024 && n < 5000) begin
            if ($urandom_range(0, 3) != 0 && may_write()) begin
                write_one(1'b0); w++;
            end
            step(); n++;
        end
        check_val("t5_writer_timeout", w, 1024);
        repeat (20) step();
        check_val("t5_wrap_addr0", rd_addr0, 6); check_val("t5_wrap_en0", rd_en0, 0);
        pulse_stop();
        wait_idle(100, d0, d1);
        check_val("t5_chk0", chk0, 1030); check_val("t5_chk1", chk1, 1030);
        check_val("t5_err0", err0, 0);    check_val("t5_err1", err1, 0);

        // randomized runs with corrupted words, random stops and starts
        repeat (12) begin
            wait_idle(200, d0, d1);
            rd_count = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
            pulse_start();
            for (int c = 0; c < 60; c++) begin
                if ($urandom_range(0, 2) != 0 && may_write())
                    write_one($urandom_range(0, 7) == 0);
                stop  = ($urandom_range(0, 29) == 0);
                start = busy0 && busy1 && ($urandom_range(0, 19) == 0);
                step();
            end
            start = 1'b0;
            pulse_stop();
            wait_idle(200, d0, d1);
        end

        // reset asserted with reads in flight
        wr_addr = 10'd500; rd_count = 16'd0;
        pulse_start();
        repeat (4) step();
        reset = 1'b0;
        #1;
        check_val("t7_rd_en0", rd_en0, 0);   check_val("t7_rd_en1", rd_en1, 0);
        check_val("t7_rd_addr0", rd_addr0, 0); check_val("t7_rd_addr1", rd_addr1, 0);
        check_val("t7_busy0", busy0, 0);     check_val("t7_busy1", busy1, 0);
        check_val("t7_done0", done0, 0);     check_val("t7_done1", done1, 0);
        check_val("t7_mis0", mis0, 0);       check_val("t7_mis1", mis1, 0);
        check_val("t7_err0", err0, 0);       check_val("t7_err1", err1, 0);
        check_val("t7_chk0", chk0, 0);       check_val("t7_chk1", chk1, 0);
        step(); step();
        reset = 1'b1;
        repeat (10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
